// File: rtl/tia_object_bank.sv
// Bank of TIA-style movable objects: per-object position counters, HMOVE fine motion,
// scaled/reflected graphics serialisation, and optional sticky pair collisions (TIA_OBJECT_BANK_COLLISION_EN).
module tia_object_bank #(
    parameter int unsigned NUM_OBJ  = 5,
    parameter int unsigned GFX_W    = 8,
    parameter int unsigned LINE_LEN = 160,
    localparam int unsigned OW    = $clog2(NUM_OBJ),
    localparam int unsigned CW    = $clog2(LINE_LEN),
    localparam int unsigned NPAIR = NUM_OBJ * (NUM_OBJ - 1) / 2
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic             pix_en,
    input  logic             hblank,
    input  logic             hmove,
    input  logic             hmclr,
    input  logic             wr_en,
    input  logic [OW-1:0]    wr_obj,
    input  logic [1:0]       wr_sel,
    input  logic [GFX_W-1:0] wr_data,
    input  logic             cxclr,
    output logic [NUM_OBJ-1:0] obj_out,
    output logic [NPAIR-1:0] cx_out,
    output logic             moving
);

    localparam int unsigned IW = $clog2(GFX_W * 4);
    localparam int unsigned KW = $clog2(GFX_W);
    localparam logic [CW-1:0] POS_LAST = CW'(LINE_LEN - 1);
    localparam logic [1:0] SEL_POS = 2'd0;
    localparam logic [1:0] SEL_MOT = 2'd1;
    localparam logic [1:0] SEL_GFX = 2'd2;
    localparam logic [1:0] SEL_CTL = 2'd3;

    logic [CW-1:0]    pos_q [NUM_OBJ];
    logic [CW-1:0]    pos_n [NUM_OBJ];
    logic [3:0]       mot_q [NUM_OBJ];
    logic [3:0]       mot_n [NUM_OBJ];
    logic [GFX_W-1:0] gfx_q [NUM_OBJ];
    logic [GFX_W-1:0] gfx_n [NUM_OBJ];
    logic [2:0]       ctl_q [NUM_OBJ];
    logic [2:0]       ctl_n [NUM_OBJ];
    logic [IW-1:0]    idx_q [NUM_OBJ];
    logic [IW-1:0]    idx_n [NUM_OBJ];
    logic [4:0]       rem_q [NUM_OBJ];
    logic [4:0]       rem_n [NUM_OBJ];
    logic [NUM_OBJ-1:0] act_q;
    logic [NUM_OBJ-1:0] act_n;
    logic [NUM_OBJ-1:0] obj_q;
    logic [NUM_OBJ-1:0] obj_n;
    logic [NUM_OBJ-1:0] pix_c;
    logic             moving_q;
    logic             moving_n;

    logic             hit;
    logic             pos_wr;
    logic             extra;
    logic [1:0]       sh;
    logic [KW-1:0]    k;

    // Per-object next state: pixel, draw sequencing, position, motion pulses, register writes
    always_comb begin
        hit      = 1'b0;
        pos_wr   = 1'b0;
        extra    = 1'b0;
        sh       = 2'd0;
        k        = '0;
        moving_n = 1'b0;
        pix_c    = '0;
        obj_n    = obj_q;
        act_n    = act_q;
        for (int o = 0; o < NUM_OBJ; o++) begin
            pos_n[o] = pos_q[o];
            mot_n[o] = mot_q[o];
            gfx_n[o] = gfx_q[o];
            ctl_n[o] = ctl_q[o];
            idx_n[o] = idx_q[o];
            rem_n[o] = rem_q[o];

            hit    = wr_en && (wr_obj == OW'(o));
            pos_wr = hit && (wr_sel == SEL_POS);
            extra  = hblank && !pix_en && (rem_q[o] != 5'd0);
            sh     = (ctl_q[o][1:0] == 2'd0) ? 2'd0 :
                     (ctl_q[o][1:0] == 2'd1) ? 2'd1 : 2'd2;
            k      = KW'(idx_q[o] >> sh);

            pix_c[o] = act_q[o] & (ctl_q[o][2] ? gfx_q[o][k]
                                               : gfx_q[o][KW'(GFX_W - 1) - k]);
            if (pix_en) begin
                obj_n[o] = pix_c[o];
            end

            if (pix_en && act_q[o]) begin
                if (idx_q[o] == IW'((GFX_W << sh) - 1)) begin
                    act_n[o] = 1'b0;
                end else begin
                    idx_n[o] = idx_q[o] + IW'(1);
                end
            end

            // A position write beats both the pixel clock and any pending motion pulse
            if (pos_wr) begin
                pos_n[o] = '0;
                act_n[o] = 1'b0;
                idx_n[o] = '0;
            end else if (pix_en || extra) begin
                if (pos_q[o] == POS_LAST) begin
                    pos_n[o] = '0;
                    act_n[o] = 1'b1;
                    idx_n[o] = '0;
                end else begin
                    pos_n[o] = pos_q[o] + CW'(1);
                end
            end

            // 8 + signed motion, computed mod 32 so -8..7 maps onto 0..15
            if (hmove) begin
                rem_n[o] = 5'd8 + {mot_q[o][3], mot_q[o]};
            end else if (extra && !pos_wr) begin
                rem_n[o] = rem_q[o] - 5'd1;
            end

            if (hit && (wr_sel == SEL_MOT)) begin
                mot_n[o] = wr_data[3:0];
            end else if (hmclr) begin
                mot_n[o] = '0;
            end
            if (hit && (wr_sel == SEL_GFX)) begin
                gfx_n[o] = wr_data;
            end
            if (hit && (wr_sel == SEL_CTL)) begin
                ctl_n[o] = wr_data[2:0];
            end

            moving_n = moving_n | (rem_n[o] != 5'd0);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            for (int o = 0; o < NUM_OBJ; o++) begin
                pos_q[o] <= '0;
                mot_q[o] <= '0;
                gfx_q[o] <= '0;
                ctl_q[o] <= '0;
                idx_q[o] <= '0;
                rem_q[o] <= '0;
            end
            act_q    <= '0;
            obj_q    <= '0;
            moving_q <= 1'b0;
        end else begin
            pos_q    <= pos_n;
            mot_q    <= mot_n;
            gfx_q    <= gfx_n;
            ctl_q    <= ctl_n;
            idx_q    <= idx_n;
            rem_q    <= rem_n;
            act_q    <= act_n;
            obj_q    <= obj_n;
            moving_q <= moving_n;
        end
    end

    assign obj_out = obj_q;
    assign moving  = moving_q;

`ifdef TIA_OBJECT_BANK_COLLISION_EN
    logic [NPAIR-1:0] cx_q;
    logic [NPAIR-1:0] cx_n;

    // Sticky pair latches; a fresh hit outranks a same-cycle clear
    always_comb begin
        cx_n = cxclr ? '0 : cx_q;
        if (pix_en) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                for (int j = i + 1; j < NUM_OBJ; j++) begin
                    cx_n[i * (2 * NUM_OBJ - i - 1) / 2 + (j - i - 1)] =
                        cx_n[i * (2 * NUM_OBJ - i - 1) / 2 + (j - i - 1)] | (pix_c[i] & pix_c[j]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            cx_q <= '0;
        end else begin
            cx_q <= cx_n;
        end
    end

    assign cx_out = cx_q;
`else
    logic unused_cxclr;
    assign unused_cxclr = cxclr;
    assign cx_out       = '0;
`endif

endmodule

// File: tb/tb_tia_object_bank.sv
// Scoreboard bench for tia_object_bank: a behavioural model queues expected outputs per clock,
// plus directed checks of pixel timing, HMOVE pulse counts, collisions and reset.
module tb_tia_object_bank;

    localparam int NO = 5;
    localparam int GW = 8;
    localparam int LL = 160;
    localparam int NP = 10;
`ifdef TIA_OBJECT_BANK_COLLISION_EN
    localparam logic COLL = 1'b1;
`else
    localparam logic COLL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_bar = 1'b1;
    logic          pix_en, hblank, hmove, hmclr, wr_en, cxclr;
    logic [2:0]    wr_obj;
    logic [1:0]    wr_sel;
    logic [GW-1:0] wr_data;
    logic [NO-1:0] obj_out;
    logic [NP-1:0] cx_out;
    logic          moving;

    tia_object_bank dut (
        .clk       (clk),
        .reset_bar (reset_bar),
        .pix_en    (pix_en),
        .hblank    (hblank),
        .hmove     (hmove),
        .hmclr     (hmclr),
        .wr_en     (wr_en),
        .wr_obj    (wr_obj),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .cxclr     (cxclr),
        .obj_out   (obj_out),
        .cx_out    (cx_out),
        .moving    (moving)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NO-1:0] obj;
        logic [NP-1:0] cx;
        logic          mov;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int m_pos [NO];
    int m_mot [NO];
    int m_gfx [NO];
    int m_ctl [NO];
    int m_idx [NO];
    int m_act [NO];
    int m_rem [NO];
    logic [NO-1:0] m_obj;
    logic [NP-1:0] m_cx;
    logic          m_mov;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scale_of(input int ctl);
        return ((ctl & 3) == 0) ? 1 : (((ctl & 3) == 1) ? 2 : 4);
    endfunction

    function automatic logic model_pix(input int o);
        int kk;
        if (m_act[o] == 0) return 1'b0;
        kk = m_idx[o] / scale_of(m_ctl[o]);
        if ((m_ctl[o] & 4) != 0) return 1'(m_gfx[o] >> kk);
        return 1'(m_gfx[o] >> (GW - 1 - kk));
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_pos[o] = 0; m_mot[o] = 0; m_gfx[o] = 0; m_ctl[o] = 0;
            m_idx[o] = 0; m_act[o] = 0; m_rem[o] = 0;
        end
        m_obj = '0;
        m_cx  = '0;
        m_mov = 1'b0;
        sb.delete();
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        logic px [NO];
        logic hit, pw, ex;
        int   p;
        exp_t e;
        for (int o = 0; o < NO; o++) px[o] = model_pix(o);
`ifdef TIA_OBJECT_BANK_COLLISION_EN
        if (cxclr) m_cx = '0;
        if (pix_en) begin
            p = 0;
            for (int i = 0; i < NO; i++) begin
                for (int j = i + 1; j < NO; j++) begin
                    if (px[i] && px[j]) m_cx[p] = 1'b1;
                    p++;
                end
            end
        end
`endif
        m_mov = 1'b0;
        for (int o = 0; o < NO; o++) begin
            hit = wr_en && (int'(wr_obj) == o);
            pw  = hit && (wr_sel == 2'd0);
            ex  = hblank && !pix_en && (m_rem[o] > 0);
            if (pix_en) m_obj[o] = px[o];
            if (pix_en && m_act[o] != 0) begin
                if (m_idx[o] == GW * scale_of(m_ctl[o]) - 1) m_act[o] = 0;
                else m_idx[o]++;
            end
            if (pw) begin
                m_pos[o] = 0;
                m_act[o] = 0;
            end else if (pix_en || ex) begin
                if (m_pos[o] == LL - 1) begin
                    m_pos[o] = 0; m_act[o] = 1; m_idx[o] = 0;
                end else begin
                    m_pos[o]++;
                end
            end
            if (hmove) m_rem[o] = 8 + m_mot[o];
            else if (ex && !pw) m_rem[o]--;
            if (hit && wr_sel == 2'd1)
                m_mot[o] = wr_data[3] ? int'(wr_data[3:0]) - 16 : int'(wr_data[3:0]);
            else if (hmclr) m_mot[o] = 0;
            if (hit && wr_sel == 2'd2) m_gfx[o] = int'(wr_data);
            if (hit && wr_sel == 2'd3) m_ctl[o] = int'(wr_data[2:0]);
            if (m_rem[o] > 0) m_mov = 1'b1;
        end
        e.obj = m_obj;
        e.cx  = m_cx;
        e.mov = m_mov;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("sb_obj", 32'(obj_out), 32'(e.obj));
            check("sb_cx",  32'(cx_out),  32'(e.cx));
            check("sb_mov", 32'(moving),  32'(e.mov));
        end
    endtask

    task automatic idle();
        pix_en = 0; hblank = 0; hmove = 0; hmclr = 0; cxclr = 0;
        wr_en = 0; wr_obj = '0; wr_sel = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_bar = 1'b0;
        #1;
        check("rst_obj", 32'(obj_out), 32'd0);
        check("rst_cx",  32'(cx_out),  32'd0);
        check("rst_mov", 32'(moving),  32'd0);
        model_reset();
        @(posedge clk);
        #2;
        reset_bar = 1'b1;
        #1;
    endtask

    task automatic wr(input int o, input int s, input int d);
        wr_en = 1; wr_obj = 3'(o); wr_sel = 2'(s); wr_data = GW'(d);
        tick();
        wr_en = 0;
    endtask

    task automatic px_ticks(input int n);
        pix_en = 1;
        repeat (n) tick();
        pix_en = 0;
    endtask

    int mask, cnt, first;

    initial begin
        idle();
        #1;
        do_reset();

        // Plain x1 graphics: pixels 1 and 8 after the wrap; write to object 5 is dropped
        wr(0, 2, 8'h81); wr(5, 2, 8'hFF); wr(0, 3, 0);
        px_ticks(LL);
        mask = 0; pix_en = 1;
        for (int i = 0; i < 10; i++) begin tick(); if (obj_out[0]) mask |= (1 << i); end
        pix_en = 0;
        check("x1_mask", 32'(mask), 32'h81);

        // Reflected x2: draw index 12..15
        do_reset();
        wr(0, 2, 8'hC0); wr(0, 3, 8'h05);
        px_ticks(LL);
        mask = 0; pix_en = 1;
        for (int i = 0; i < 20; i++) begin tick(); if (obj_out[0]) mask |= (1 << i); end
        pix_en = 0;
        check("x2r_mask", 32'(mask), 32'hF000);

        // m=+7: 15 pulses, object lands 15 pixels early
        do_reset();
        wr(0, 1, 8'h07); wr(0, 2, 8'h80);
        hblank = 1; hmove = 1; cnt = 0;
        tick(); cnt += int'(moving); hmove = 0;
        repeat (30) begin tick(); cnt += int'(moving); end
        hblank = 0;
        check("m7_pulses", 32'(cnt), 32'd15);
        first = 0; pix_en = 1;
        for (int i = 1; i <= 200; i++) begin tick(); if (obj_out[0] && first == 0) first = i; end
        pix_en = 0;
        check("m7_first_px", 32'(first), 32'd146);

        // hmclr clears object 0 while a same-cycle motion write to object 1 survives
        hmclr = 1; wr(1, 1, 8'h05); hmclr = 0;
        hblank = 1; hmove = 1; cnt = 0;
        tick(); cnt += int'(moving); hmove = 0;
        repeat (30) begin tick(); cnt += int'(moving); end
        hblank = 0;
        check("hmclr_pulses", 32'(cnt), 32'd13);

        // m=-8 everywhere: no pulses; then restart mid-sequence at 11
        do_reset();
        for (int o = 0; o < NO; o++) wr(o, 1, 8'h08);
        hblank = 1; hmove = 1; cnt = 0;
        tick(); cnt += int'(moving); hmove = 0;
        repeat (5) begin tick(); cnt += int'(moving); end
        check("m8_pulses", 32'(cnt), 32'd0);
        wr(0, 1, 8'h03);
        hmove = 1; tick(); hmove = 0;
        repeat (4) tick();
        check("m3_midseq", 32'(moving), 32'd1);
        hmove = 1; cnt = 0;
        tick(); cnt += int'(moving); hmove = 0;
        repeat (30) begin tick(); cnt += int'(moving); end
        hblank = 0;
        check("restart_pulses", 32'(cnt), 32'd11);

        // Overlapping objects 0 and 1
        do_reset();
        wr(0, 2, 8'hFF); wr(1, 2, 8'hFF);
        px_ticks(40);
        wr(0, 0, 0); wr(1, 0, 0);
        px_ticks(LL + 10);
        check("cx_set", 32'(cx_out[0]), 32'(COLL));
        repeat (3) tick();
        check("cx_hold", 32'(cx_out[0]), 32'(COLL));
        cxclr = 1; tick(); cxclr = 0;
        check("cx_clr", 32'(cx_out[0]), 32'd0);
        wr(0, 0, 0); wr(1, 0, 0);
        px_ticks(LL + 3);
        cxclr = 1; pix_en = 1; tick(); cxclr = 0; pix_en = 0;
        check("cx_set_wins", 32'(cx_out[0]), 32'(COLL));
        check("cx_other", 32'(cx_out[NP-1:1]), 32'd0);

        // Reset mid-draw and mid-HMOVE
        do_reset();
        wr(0, 2, 8'hFF); wr(0, 3, 8'h02); wr(0, 1, 8'h05);
        px_ticks(LL + 5);
        check("pre_rst_draw", 32'(obj_out[0]), 32'd1);
        hblank = 1; hmove = 1; tick(); hmove = 0;
        repeat (2) tick();
        check("pre_rst_mov", 32'(moving), 32'd1);
        do_reset();
        hblank = 1; cnt = 0;
        repeat (20) begin tick(); cnt += int'(moving); end
        hblank = 0;
        check("post_rst_mov", 32'(cnt), 32'd0);
        cnt = 0; pix_en = 1;
        repeat (LL + 20) begin tick(); cnt += int'(obj_out[0]); end
        pix_en = 0;
        check("post_rst_pix", 32'(cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tia_object_bank.md
TIA_OBJECT_BANK -- requirements
Module: tia_object_bank

Interface
REQ-001 Parameter NUM_OBJ, 5, number of movable objects (2..8).
REQ-002 Parameter GFX_W, 8, graphics bits per object.
REQ-003 Parameter LINE_LEN, 160, visible pixel positions per line.
REQ-004 Parameters: OW = clog2(NUM_OBJ); CW = clog2(LINE_LEN); NPAIR = NUM_OBJ*(NUM_OBJ-1)/2.
REQ-005 Port clk, in, 1, single clock. One clock; reset is asynchronous and active-low.
REQ-006 Port reset_bar, in, 1, asynchronous active-low reset.
REQ-007 Port pix_en, in, 1, one-cycle strobe per visible pixel.
REQ-008 Port hblank, in, 1, horizontal blank; gates HMOVE extra pulses.
REQ-009 Port hmove, in, 1, one-cycle start of motion sequence.
REQ-010 Port hmclr, in, 1, clear all motion registers.
REQ-011 Port wr_en / wr_obj / wr_sel / wr_data, in, 1 / OW / 2 / GFX_W, register write; wr_sel 0=position reset, 1=motion, 2=graphics, 3=control.
REQ-012 Port cxclr, in, 1, clear collision latches.
REQ-013 Port obj_out, out, NUM_OBJ, registered per-object pixel.
REQ-014 Port cx_out, out, NPAIR, sticky pair collisions; pair (i,j), i<j, in lexicographic order.
REQ-015 Port moving, out, 1, high while any HMOVE pulses remain.

Function
REQ-016 Each object SHALL hold pos counter (CW), motion m (signed 4-bit, wr_data[3:0]), gfx (GFX_W), ctrl (wr_data[1:0] scale: 0=x1, 1=x2, 2=x4, 3=x4; wr_data[2] reflect), draw index, draw-active flag, remaining-pulse count (5-bit).
REQ-017 pos SHALL advance by 1 per pix_en and wrap from LINE_LEN-1 to 0.
REQ-018 A wrap to 0 SHALL set draw-active with draw index 0; draw index advances per pix_en, ending after GFX_W*scale pixels.
REQ-019 While drawing, obj_out SHALL be gfx[GFX_W-1-k] (reflect=0) or gfx[k] (reflect=1), k = index/scale; otherwise 0; updated only on pix_en cycles, visible the cycle after.
REQ-020 Position write SHALL load pos=0 next cycle and abort any active draw; next draw starts at next wrap (LINE_LEN pixels later).
REQ-021 hmove SHALL load every object's remaining count with 8+m (0..15) and set moving the next cycle.
REQ-022 Each clk with hblank=1, pix_en=0 and remaining>0 SHALL advance pos by 1 (with wrap and draw start) and decrement remaining.
REQ-023 pix_en and pending pulse same cycle: pos advances 1, remaining unchanged.
REQ-024 hmove while moving SHALL reload all counts (restart).
REQ-025 Position write and extra pulse same cycle: write wins; remaining unchanged.
REQ-026 hmclr SHALL zero all m; hmclr with motion write same cycle: write wins for that object.
REQ-027 moving SHALL be 1 when any remaining>0, and 0 in the cycle after the last pulse.
REQ-028 Writes with wr_obj >= NUM_OBJ SHALL be ignored.

Reset
REQ-029 reset_bar low SHALL immediately clear pos, m, gfx, ctrl, draw state, remaining, obj_out, cx_out, moving to 0.
REQ-030 Reset mid-HMOVE or mid-draw SHALL abandon it; no pulse or pixel emitted after release without new stimulus.

Configuration
REQ-031 Macro TIA_OBJECT_BANK_COLLISION_EN defined: cx_out bit for (i,j) SHALL set on pix_en cycle where both objects' next obj_out values are 1, hold until cxclr; set and cxclr same cycle: set wins.
REQ-032 Macro undefined: cx_out SHALL be constant 0, no collision flops, cxclr ignored.

Verification
REQ-033 Reset, gfx0=8'b1000_0001, scale x1, 160 pix_en -> obj_out[0] high for 1st and 8th pixel after wrap only.
REQ-034 Same object, reflect=1, gfx0=8'b1100_0000, scale x2 -> obj_out[0] high for pixels 12..15 of draw.
REQ-035 m=+7, hmove during hblank, no pix_en -> 15 extra pulses, moving high 15 cycles; object draws 15 pixels earlier on next line.
REQ-036 m=-8, hmove -> 0 pulses, moving stays 0; second hmove mid-sequence with m=3 restarts at 11 pulses.
REQ-037 With COLLISION_EN, objects 0 and 1 overlapping at pos 40 -> cx_out[0]=1 until cxclr; cxclr with new overlap same cycle -> stays 1; without macro -> cx_out=0 always.
REQ-038 reset_bar low for 1 cycle mid-draw and mid-HMOVE -> all outputs 0 immediately, moving stays 0 after release.
